// File: rtl/srm_pkg.sv
// Shared types and defaults for the picture-path SDRAM arbiter.
// Optional read/write fairness is built when SRM_WR_FAIR_EN is defined.
package srm_pkg;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_REF  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_INIT  = 2'b00,
      S_IDLE  = 2'b01,
      S_ISSUE = 2'b10,
      S_BUSY  = 2'b11
   } state_e;

   localparam int REF_PERIOD_DEF    = 780;
   localparam int REF_MAX_DEF       = 8;
   localparam int REF_URGENT_DEF    = 4;
   localparam int RD_STREAK_MAX_DEF = 4;
   localparam int REF_PEND_W        = 4;

   // Fixed priority ladder; wr_first is only ever set by the fairness logic.
   function automatic op_e srm_pick(input logic urgent, input logic rd,
                                    input logic wr, input logic wr_first,
                                    input logic pend_nz);
      if (urgent)        return OP_REF;
      else if (wr_first) return OP_WR;
      else if (rd)       return OP_RD;
      else if (wr)       return OP_WR;
      else if (pend_nz)  return OP_REF;
      else               return OP_NONE;
   endfunction

endpackage

// File: rtl/srm_if.sv
// Request/grant and command-engine handshake bundle for srm_arb.
interface srm_if;
   import srm_pkg::*;

   logic                  init_done;
   logic                  rd_req;
   logic                  wr_req;
   logic                  op_done;
   logic                  op_start;
   logic [1:0]            op_type;
   logic                  rd_gnt;
   logic                  wr_gnt;
   logic [REF_PEND_W-1:0] ref_pend;
   logic                  busy;

   modport slave (
      input  init_done, rd_req, wr_req, op_done,
      output op_start, op_type, rd_gnt, wr_gnt, ref_pend, busy
   );

   modport master (
      output init_done, rd_req, wr_req, op_done,
      input  op_start, op_type, rd_gnt, wr_gnt, ref_pend, busy
   );

endinterface

// File: rtl/srm_ref_timer.sv
// Refresh period counter plus saturating pending-credit counter.
module srm_ref_timer
   import srm_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int REF_MAX    = REF_MAX_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inc_en_i,
   input  logic                  dec_i,
   output logic [REF_PEND_W-1:0] ref_pend_o
);

   localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REF_PEND_W-1:0] pend_q, pend_d;
   logic                  wrap;

   assign wrap = inc_en_i && (cnt_q == CNT_W'(REF_PERIOD - 1));

   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      if (!inc_en_i || wrap) cnt_d = '0;
      // A credit earned and a credit spent in the same cycle cancel out.
      pend_d = pend_q;
      if (wrap && !dec_i && (pend_q < REF_PEND_W'(REF_MAX)))
         pend_d = pend_q + REF_PEND_W'(1);
      else if (dec_i && !wrap && (pend_q != '0))
         pend_d = pend_q - REF_PEND_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pend_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   assign ref_pend_o = pend_q;

endmodule

// File: rtl/srm_arb.sv
// Read/write/refresh arbiter and one-op-at-a-time sequencer for the SDRAM engine.
// Define SRM_WR_FAIR_EN to force a write slot after RD_STREAK_MAX consecutive reads.
module srm_arb
   import srm_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int REF_MAX    = REF_MAX_DEF,
   parameter int REF_URGENT = REF_URGENT_DEF
`ifdef SRM_WR_FAIR_EN
   ,parameter int RD_STREAK_MAX = RD_STREAK_MAX_DEF
`endif
) (
   input logic  clk,
   input logic  rst_n,
   srm_if.slave bus
);

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   op_e                   sel;
   logic [REF_PEND_W-1:0] ref_pend;
   logic                  op_start;
   logic                  ref_dec;
   logic                  urgent;
   logic                  wr_first;

   srm_ref_timer #(
      .REF_PERIOD (REF_PERIOD),
      .REF_MAX    (REF_MAX)
   ) u_ref_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_en_i   (bus.init_done),
      .dec_i      (ref_dec),
      .ref_pend_o (ref_pend)
   );

   assign op_start = (state_q == S_ISSUE);
   assign ref_dec  = op_start && (op_q == OP_REF);
   assign urgent   = (ref_pend >= REF_PEND_W'(REF_URGENT));

`ifdef SRM_WR_FAIR_EN
   localparam int STK_W = $clog2(RD_STREAK_MAX + 1);

   logic [STK_W-1:0] streak_q, streak_d;

   // Saturates at the limit so a long read run cannot wrap back to zero.
   always_comb begin
      streak_d = streak_q;
      if (op_start) begin
         if (op_q != OP_RD)
            streak_d = '0;
         else if (streak_q < STK_W'(RD_STREAK_MAX))
            streak_d = streak_q + STK_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) streak_q <= '0;
      else        streak_q <= streak_d;
   end

   assign wr_first = bus.wr_req && (streak_q >= STK_W'(RD_STREAK_MAX));
`else
   assign wr_first = 1'b0;
`endif

   assign sel = srm_pick(urgent, bus.rd_req, bus.wr_req, wr_first, ref_pend != '0);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      unique case (state_q)
         S_INIT:
            if (bus.init_done) state_d = S_IDLE;
         S_IDLE:
            if (!bus.init_done) begin
               state_d = S_INIT;
            end else if (sel != OP_NONE) begin
               op_d    = sel;
               state_d = S_ISSUE;
            end
         S_ISSUE:
            state_d = S_BUSY;
         // A launched op always runs to op_done, even if init_done drops.
         S_BUSY:
            if (bus.op_done) begin
               op_d    = OP_NONE;
               state_d = bus.init_done ? S_IDLE : S_INIT;
            end
         default: begin
            state_d = S_INIT;
            op_d    = OP_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         op_q    <= OP_NONE;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   assign bus.op_start = op_start;
   assign bus.op_type  = op_q;
   assign bus.rd_gnt   = op_start && (op_q == OP_RD);
   assign bus.wr_gnt   = op_start && (op_q == OP_WR);
   assign bus.ref_pend = ref_pend;
   assign bus.busy     = (state_q == S_ISSUE) || (state_q == S_BUSY);

endmodule

// File: tb/tb_srm_arb.sv
// Directed bench for srm_arb with a shortened refresh period of 20 cycles.
module tb_srm_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   srm_if bus ();

   srm_arb #(.REF_PERIOD(20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.init_done = 1'b0;
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      bus.op_done = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int seen;
      bus.init_done = 1'b0;
      bus.rd_req = 1'b1;
      bus.wr_req = 1'b0;
      bus.op_done = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.busy, bus.op_type} !== 6'b0) begin
         bad++; $display("FAIL reset_outputs got=%b want=000000",
                         {bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.busy, bus.op_type});
      end
      total++;
      if (bus.ref_pend !== 4'd0) begin
         bad++; $display("FAIL reset_ref_pend got=%0d want=0", bus.ref_pend);
      end
      rst_n = 1'b1;
      seen = 0;
      repeat (100) begin
         tick();
         if (bus.op_start !== 1'b0) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++; $display("FAIL no_start_before_init got=%0d want=0", seen);
      end
      bus.init_done = 1'b1;
      tick();
      total++;
      if (bus.op_start !== 1'b0) begin
         bad++; $display("FAIL init_latency_early got=%b want=0", bus.op_start);
      end
      tick();
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.op_type} !== 5'b11001) begin
         bad++; $display("FAIL first_read_issue got=%b want=11001",
                         {bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.op_type});
      end
      bus.rd_req = 1'b0;
      tick();
      total++;
      if ({bus.busy, bus.op_start, bus.op_type} !== 4'b1001) begin
         bad++; $display("FAIL read_busy_hold got=%b want=1001",
                         {bus.busy, bus.op_start, bus.op_type});
      end
      bus.op_done = 1'b1;
      #1;
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL busy_in_done_cycle got=%b want=1", bus.busy);
      end
      tick();
      bus.op_done = 1'b0;
      total++;
      if ({bus.busy, bus.op_type} !== 3'b000) begin
         bad++; $display("FAIL op_type_cleared got=%b want=000", {bus.busy, bus.op_type});
      end
   endtask

   task automatic test_rd_over_wr();
      int nrd, nwr, run, maxrun;
      bit got;
      do_reset();
      bus.init_done = 1'b1;
      bus.rd_req = 1'b1;
      bus.wr_req = 1'b1;
      nrd = 0; nwr = 0; run = 0; maxrun = 0;
      for (int k = 0; k < 16; k++) begin
         got = 1'b0;
         for (int w = 0; w < 20 && !got; w++) begin
            tick();
            if (bus.op_start === 1'b1) got = 1'b1;
         end
         total++;
         if (!got) begin
            bad++; $display("FAIL mix_start_timeout op=%0d got=none want=op_start", k);
            break;
         end
         total++;
         if ({bus.rd_gnt, bus.wr_gnt} !== {bus.op_type == 2'b01, bus.op_type == 2'b10}) begin
            bad++; $display("FAIL mix_gnt_vs_type got=%b type=%b", {bus.rd_gnt, bus.wr_gnt}, bus.op_type);
         end
         if (bus.op_type == 2'b01) begin
            nrd++; run++;
            if (run > maxrun) maxrun = run;
         end else begin
            if (bus.op_type == 2'b10) nwr++;
            run = 0;
         end
         repeat (5) tick();
         bus.op_done = 1'b1;
         tick();
         bus.op_done = 1'b0;
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
`ifdef SRM_WR_FAIR_EN
      total++;
      if (maxrun !== 4) begin
         bad++; $display("FAIL fair_read_streak got=%0d want=4", maxrun);
      end
      total++;
      if (nwr < 2) begin
         bad++; $display("FAIL fair_write_slots got=%0d want>=2", nwr);
      end
`else
      total++;
      if (nwr !== 0) begin
         bad++; $display("FAIL strict_no_writes got=%0d want=0", nwr);
      end
      total++;
      if (nrd < 14) begin
         bad++; $display("FAIL strict_reads got=%0d want>=14", nrd);
      end
`endif
   endtask

   task automatic test_refresh();
      int t, maxp;
      bit got;
      do_reset();
      bus.init_done = 1'b1;
      t = 0;
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
         tick();
         t++;
         if (bus.op_start === 1'b1) got = 1'b1;
      end
      total++;
      if (t !== 21) begin
         bad++; $display("FAIL first_refresh_cycle got=%0d want=21", t);
      end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            got = 1'b0;
            for (int w = 0; w < 30 && !got; w++) begin
               tick();
               if (bus.op_start === 1'b1) got = 1'b1;
            end
            total++;
            if (!got) begin
               bad++; $display("FAIL refresh_timeout iter=%0d got=none want=op_start", k);
            end
         end
         total++;
         if ({bus.op_type, bus.rd_gnt, bus.wr_gnt} !== 4'b1100) begin
            bad++; $display("FAIL refresh_type iter=%0d got=%b want=1100", k,
                            {bus.op_type, bus.rd_gnt, bus.wr_gnt});
         end
         tick();
         total++;
         if (bus.ref_pend !== 4'd0) begin
            bad++; $display("FAIL refresh_drain iter=%0d got=%0d want=0", k, bus.ref_pend);
         end
         bus.op_done = 1'b1;
         tick();
         bus.op_done = 1'b0;
      end
      got = 1'b0;
      for (int w = 0; w < 30 && !got; w++) begin
         tick();
         if (bus.op_start === 1'b1) got = 1'b1;
      end
      maxp = 0;
      repeat (200) begin
         tick();
         if (int'(bus.ref_pend) > maxp) maxp = int'(bus.ref_pend);
      end
      total++;
      if (maxp !== 8) begin
         bad++; $display("FAIL ref_pend_peak got=%0d want=8", maxp);
      end
      total++;
      if (bus.ref_pend !== 4'd8) begin
         bad++; $display("FAIL ref_pend_saturated got=%0d want=8", bus.ref_pend);
      end
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
   endtask

   task automatic test_urgent();
      bit got;
      do_reset();
      bus.init_done = 1'b1;
      repeat (21) tick();
      got = 1'b0;
      for (int w = 0; w < 120 && !got; w++) begin
         tick();
         if (bus.ref_pend === 4'd4) got = 1'b1;
      end
      total++;
      if (!got) begin
         bad++; $display("FAIL urgent_setup_timeout got=%0d want=4", bus.ref_pend);
      end
      bus.op_done = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      bus.op_done = 1'b0;
      total++;
      if ({bus.op_start, bus.op_type} !== 3'b000) begin
         bad++; $display("FAIL idle_gap got=%b want=000", {bus.op_start, bus.op_type});
      end
      tick();
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.op_type} !== 4'b1011) begin
         bad++; $display("FAIL urgent_refresh_first got=%b want=1011",
                         {bus.op_start, bus.rd_gnt, bus.op_type});
      end
      tick();
      total++;
      if (bus.ref_pend !== 4'd3) begin
         bad++; $display("FAIL urgent_dec got=%0d want=3", bus.ref_pend);
      end
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
      tick();
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.op_type} !== 4'b1101) begin
         bad++; $display("FAIL read_after_urgent got=%b want=1101",
                         {bus.op_start, bus.rd_gnt, bus.op_type});
      end
      bus.rd_req = 1'b0;
      tick();
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
   endtask

   task automatic test_reset_busy();
      do_reset();
      bus.init_done = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      tick();
      bus.rd_req = 1'b0;
      tick();
      total++;
      if ({bus.busy, bus.op_type} !== 3'b101) begin
         bad++; $display("FAIL busy_before_reset got=%b want=101", {bus.busy, bus.op_type});
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.busy, bus.op_type, bus.ref_pend} !== 10'b0) begin
         bad++; $display("FAIL async_reset_outputs got=%b want=0",
                         {bus.op_start, bus.rd_gnt, bus.wr_gnt, bus.busy, bus.op_type, bus.ref_pend});
      end
      tick();
      rst_n = 1'b1;
      bus.op_done = 1'b1;
      bus.rd_req = 1'b1;
      tick();
      bus.op_done = 1'b0;
      total++;
      if ({bus.op_start, bus.busy} !== 2'b00) begin
         bad++; $display("FAIL stale_done_ignored got=%b want=00", {bus.op_start, bus.busy});
      end
      tick();
      total++;
      if ({bus.op_start, bus.rd_gnt, bus.op_type} !== 4'b1101) begin
         bad++; $display("FAIL restart_read got=%b want=1101",
                         {bus.op_start, bus.rd_gnt, bus.op_type});
      end
      bus.rd_req = 1'b0;
      tick();
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
   endtask

   task automatic test_wrap_grant();
      do_reset();
      bus.init_done = 1'b1;
      repeat (21) tick();
      total++;
      if ({bus.op_start, bus.op_type} !== 3'b111) begin
         bad++; $display("FAIL wrap_setup_refresh got=%b want=111", {bus.op_start, bus.op_type});
      end
      repeat (76) tick();
      total++;
      if (bus.ref_pend !== 4'd3) begin
         bad++; $display("FAIL wrap_setup_pend got=%0d want=3", bus.ref_pend);
      end
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
      tick();
      total++;
      if ({bus.op_start, bus.op_type, bus.ref_pend} !== 7'b1110011) begin
         bad++; $display("FAIL wrap_grant_issue got=%b want=1110011",
                         {bus.op_start, bus.op_type, bus.ref_pend});
      end
      tick();
      total++;
      if (bus.ref_pend !== 4'd3) begin
         bad++; $display("FAIL wrap_and_grant got=%0d want=3", bus.ref_pend);
      end
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rd_over_wr();
      test_refresh();
      test_urgent();
      test_reset_busy();
      test_wrap_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
